// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction RAM loader and PC sequencer (IDLE/LOAD/RUN/HALT); IFETCH_PERF_CNT_EN adds cycle_cnt/stall_cnt
module imem_fetch_ctrl #(
  parameter int          DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [31:0]              load_data,
  input  logic                     load_last,
  output logic                     imem_we,
  output logic [$clog2(DEPTH)-1:0] imem_waddr,
  output logic [31:0]              imem_wdata,
  input  logic                     stall,
  input  logic                     br_taken,
  input  logic [31:0]              br_target,
  output logic [31:0]              pc,
  output logic                     fetch_valid,
  output logic                     halted,
  output logic [1:0]               fault
`ifdef IFETCH_PERF_CNT_EN
  ,output logic [31:0]             cycle_cnt
  ,output logic [31:0]             stall_cnt
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [31:0] LIMIT = 32'(DEPTH * 4);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;
  state_t state;
  logic [AW-1:0] ptr;
  logic [31:0] nxt_pc;
  logic hs;
  assign load_ready  = state == LOAD;
  assign fetch_valid = state == RUN;
  assign halted      = state == HALT;
  assign hs          = load_valid && load_ready;
  assign imem_we     = hs;
  assign imem_waddr  = ptr;
  assign imem_wdata  = load_data;
  assign nxt_pc      = br_taken ? br_target : stall ? pc : pc + 32'd4;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      pc    <= RESET_PC;
      ptr   <= '0;
      fault <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load_valid) begin
            state <= LOAD;
            ptr   <= '0;
          end else if (start) begin
            state <= RUN;
            pc    <= RESET_PC;
          end
        end
        LOAD: begin
          if (hs) begin
            ptr <= ptr + 1'b1;
            if (load_last) state <= IDLE;
            else if (ptr == AW'(DEPTH - 1)) begin
              state <= HALT;
              fault <= 2'd3;
            end
          end
        end
        RUN: begin
          if (br_taken && |br_target[1:0]) begin
            state <= HALT;
            fault <= 2'd1;
          end else if (nxt_pc >= LIMIT) begin
            state <= HALT;
            fault <= 2'd2;
          end else pc <= nxt_pc;
        end
        default: ;
      endcase
    end
  end
`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cycle_cnt <= '0;
      stall_cnt <= '0;
    end else if (state == RUN) begin
      if (~&cycle_cnt) cycle_cnt <= cycle_cnt + 32'd1;
      if (stall && !br_taken && ~&stall_cnt) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`else
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: scoreboard bench with a mode-level reference model of the fetch controller
module tb_imem_fetch_ctrl;
  localparam int DEPTH = 64;
  localparam logic [31:0] RPC = 32'h0;
  logic clk = 0, reset_n = 0, start = 0, load_valid = 0, load_last = 0, stall = 0, br_taken = 0;
  logic [31:0] load_data = 0, br_target = 0;
  logic load_ready, imem_we, fetch_valid, halted;
  logic [5:0] imem_waddr;
  logic [31:0] imem_wdata, pc;
  logic [1:0] fault;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0] cycle_cnt, stall_cnt;
`endif
  always #5 clk = ~clk;
  imem_fetch_ctrl #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_last(load_last), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .stall(stall), .br_taken(br_taken), .br_target(br_target), .pc(pc),
    .fetch_valid(fetch_valid), .halted(halted), .fault(fault)
`ifdef IFETCH_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt)
`endif
  );
  typedef struct packed {logic lr, fv, hl, we; logic [1:0] ft; logic [31:0] pc;} stat_t;
  typedef struct packed {logic [5:0] a; logic [31:0] d;} wr_t;
  stat_t sq[$];
  wr_t wq[$];
  logic [63:0] cq[$];
  int checks = 0, errors = 0;
  int m_mode = 0, m_ptr = 0, m_fault = 0;
  longint m_pc = RPC, m_cc = 0, m_sc = 0;
  task automatic cyc(input logic rn, st, lv, ll, sl, bt, input logic [31:0] ld, tg);
    stat_t s;
    longint nx;
    @(posedge clk);
    #1;
    reset_n = rn; start = st; load_valid = lv; load_last = ll; stall = sl; br_taken = bt;
    load_data = ld; br_target = tg;
    s.lr = m_mode == 1;
    s.fv = m_mode == 2;
    s.hl = m_mode == 3;
    s.we = m_mode == 1 && lv;
    s.ft = 2'(m_fault);
    s.pc = 32'(m_pc);
    sq.push_back(s);
    cq.push_back({32'(m_cc), 32'(m_sc)});
    if (s.we) wq.push_back({6'(m_ptr), ld});
    if (!rn) begin
      m_mode = 0; m_pc = RPC; m_ptr = 0; m_fault = 0; m_cc = 0; m_sc = 0;
    end else begin
      if (m_mode == 2) begin
        if (m_cc != 64'hFFFFFFFF) m_cc++;
        if (sl && !bt && m_sc != 64'hFFFFFFFF) m_sc++;
      end
      case (m_mode)
        0: if (lv) begin m_mode = 1; m_ptr = 0; end else if (st) begin m_mode = 2; m_pc = RPC; end
        1: if (lv) begin
          if (ll) m_mode = 0;
          else if (m_ptr == DEPTH - 1) begin m_mode = 3; m_fault = 3; end
          m_ptr++;
        end
        2: begin
          nx = bt ? longint'(tg) : sl ? m_pc : m_pc + 4;
          if (bt && tg % 4 != 0) begin m_mode = 3; m_fault = 1; end
          else if (nx >= DEPTH * 4) begin m_mode = 3; m_fault = 2; end
          else m_pc = nx;
        end
        default: ;
      endcase
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin
    stat_t e, a;
    wr_t w;
    logic [63:0] c;
    if (sq.size() != 0) begin
      e = sq.pop_front();
      c = cq.pop_front();
      a = {load_ready, fetch_valid, halted, imem_we, fault, pc};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL status: got lr=%b fv=%b hl=%b we=%b ft=%0d pc=%h expected lr=%b fv=%b hl=%b we=%b ft=%0d pc=%h",
                 a.lr, a.fv, a.hl, a.we, a.ft, a.pc, e.lr, e.fv, e.hl, e.we, e.ft, e.pc);
      end
`ifdef IFETCH_PERF_CNT_EN
      checks++;
      if ({cycle_cnt, stall_cnt} !== c) begin
        errors++;
        $display("FAIL perf: got %h/%h expected %h/%h", cycle_cnt, stall_cnt, c[63:32], c[31:0]);
      end
`endif
    end
    if (imem_we === 1'b1) begin
      checks++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL write: unexpected write addr=%0d data=%h", imem_waddr, imem_wdata);
      end else begin
        w = wq.pop_front();
        if ({imem_waddr, imem_wdata} !== w) begin
          errors++;
          $display("FAIL write: got addr=%0d data=%h expected addr=%0d data=%h", imem_waddr, imem_wdata, w.a, w.d);
        end
      end
    end
  end
  initial begin
    int r;
    logic [31:0] t;
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'hAAAA0000, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'hAAAA0000, 0);
    cyc(1, 1, 1, 0, 0, 0, 32'hBBBB1111, 0);
    cyc(1, 0, 1, 1, 0, 0, 32'hCCCC2222, 0);
    idle(2);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(5);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 1, 1, 0, 32'h20);
    cyc(1, 0, 0, 0, 1, 0, 0, 0);
    idle(2);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'h22);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 0, 0, 0, 0, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'hF8);
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 0, 32'h100);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) cyc(1, 0, 1, 0, 0, 0, $urandom, 0);
    idle(1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 1, 0, 0, 0, $urandom, 0);
    cyc(0, 0, 1, 0, 0, 0, 32'h55555555, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h11111111, 0);
    cyc(1, 0, 1, 0, 0, 0, 32'h11111111, 0);
    cyc(1, 0, 1, 1, 0, 0, 32'h22222222, 0);
    idle(1);
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 9);
      t = r < 7 ? {24'h0, 6'($urandom_range(0, DEPTH - 1)), 2'b00} :
          r == 7 ? {24'h0, 6'($urandom), 2'($urandom_range(1, 3))} :
          r == 8 ? {$urandom_range(1, 255), 6'($urandom), 2'b00} : $urandom;
      cyc($urandom_range(0, 19) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom, t);
    end
    idle(1);
    @(negedge clk);
    #1;
    checks++;
    if (sq.size() > 1 || wq.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d status/%0d writes pending expected at most 1/0", sq.size(), wq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
